// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store unit memory controller:
//   - RV32I load/store funct3 encodings
//   - controller state enum
//   - default load timeout (cycles)
//   - misalignment helper used at request acceptance
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU

   localparam int unsigned TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STORE,
      ST_LOAD,
      ST_RESP
   } state_t;

   // Only the defined half/word encodings are checked; unused encodings
   // (011/110/111) behave as word accesses but are not alignment-checked.
   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if ((f3 == F3_H || f3 == F3_HU) && off[0])
         mis = 1'b1;
      if (f3 == F3_W && off != 2'b00)
         mis = 1'b1;
      return mis;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// -----------------------------------------------------------------------------
// load_formatter
// Combinational extraction and sign/zero extension of load data.
// Ports:
//   funct3   in  3  : RV32I load encoding (unused encodings act as LW)
//   byte_off in  2  : byte offset within the word (addr[1:0])
//   data_in  in  32 : raw word from data memory
//   data_out out 32 : right-aligned, extended load result
// -----------------------------------------------------------------------------
module load_formatter
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = data_in[{byte_off, 3'b000} +: 8];
      sel_half = byte_off[1] ? data_in[31:16] : data_in[15:0];
      case (funct3)
         F3_B:    data_out = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   data_out = {24'h000000, sel_byte};
         F3_H:    data_out = {{16{sel_half[15]}}, sel_half};
         F3_HU:   data_out = {16'h0000, sel_half};
         default: data_out = data_in;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// MEM-stage load/store controller between the pipeline and a word-addressed
// data memory. Stores take one memory cycle; loads wait for valid_DM up to
// TIMEOUT cycles. Misaligned accesses are rejected in the acceptance cycle.
// Ports:
//   clk, rst (sync, active-low)
//   Pipeline : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata
//   Response : rsp_valid, rsp_rdata, rsp_err, stall
//   Memory   : cs (active-low), wr (0=write), mask, data_wr, addr (word),
//              lwstallM_DM, valid_DM, data_rd
// -----------------------------------------------------------------------------
module lsu_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   // pipeline side
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   // response
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall,
   // data memory side
   output logic        cs,
   output logic        wr,
   output logic [3:0]  mask,
   output logic [31:0] data_wr,
   output logic [19:0] addr,
   output logic        lwstallM_DM,
   input  logic        valid_DM,
   input  logic [31:0] data_rd
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [21:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [2:0]    r_funct3;
   logic          r_err;
   logic [CW-1:0] cnt;

   logic          req_mis;
   logic          accept;
   logic          timeout_hit;
   logic [31:0]   fmt_data;
   logic          unused_addr_hi;

   // Word address only spans 20 bits; the top of the byte address is dropped.
   assign unused_addr_hi = ^req_addr[31:22];

   assign req_mis     = is_misaligned(req_funct3, req_addr[1:0]);
   assign accept      = (state == ST_IDLE) && req_valid && !req_mis;
   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
   assign addr        = r_addr[21:2];

   load_formatter u_fmt (
      .funct3   (r_funct3),
      .byte_off (r_addr[1:0]),
      .data_in  (data_rd),
      .data_out (fmt_data)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // request capture, load result and timeout counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_funct3  <= '0;
         r_err     <= 1'b0;
         cnt       <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            r_addr   <= req_addr[21:0];
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_err    <= 1'b0;
         end
         if (state == ST_LOAD) begin
            // data arriving on the final allowed cycle wins over the timeout
            if (valid_DM) begin
               rsp_rdata <= fmt_data;
               r_err     <= 1'b0;
               cnt       <= '0;
            end else if (timeout_hit) begin
               rsp_rdata <= '0;
               r_err     <= 1'b1;
               cnt       <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = req_we ? ST_STORE : ST_LOAD;
         ST_STORE: state_nxt = ST_RESP;
         ST_LOAD:  if (valid_DM || timeout_hit) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // output logic
   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_err     = 1'b0;
      stall       = 1'b0;
      cs          = 1'b1;
      wr          = 1'b1;
      mask        = 4'b0000;
      data_wr     = '0;
      lwstallM_DM = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_mis) begin
                  rsp_valid = 1'b1;
                  rsp_err   = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         ST_STORE: begin
            cs    = 1'b0;
            wr    = 1'b0;
            stall = 1'b1;
            case (r_funct3[1:0])
               2'b00: begin
                  mask    = 4'b0001 << r_addr[1:0];
                  data_wr = {4{r_wdata[7:0]}};
               end
               2'b01: begin
                  mask    = r_addr[1] ? 4'b1100 : 4'b0011;
                  data_wr = {2{r_wdata[15:0]}};
               end
               default: begin
                  mask    = 4'b1111;
                  data_wr = r_wdata;
               end
            endcase
         end
         ST_LOAD: begin
            cs          = 1'b0;
            stall       = 1'b1;
            lwstallM_DM = 1'b1;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = r_err;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Table-driven bench for lsu_mem_ctrl with a byte-maskable data memory model
// (all words start at 0xdeadbeef) and per-vector load latency.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, stall;
   logic [31:0] rsp_rdata;
   logic        cs, wr, lwstallM_DM, valid_DM;
   logic [3:0]  mask;
   logic [31:0] data_wr, data_rd;
   logic [19:0] addr;

   int checks   = 0;
   int failures = 0;

   lsu_mem_ctrl #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .stall(stall),
      .cs(cs), .wr(wr), .mask(mask), .data_wr(data_wr), .addr(addr),
      .lwstallM_DM(lwstallM_DM), .valid_DM(valid_DM), .data_rd(data_rd)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [31:0] mem [256];
   int          cur_lat = 0;
   int          lat_cnt = 0;
   logic        spur    = 1'b0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hdeadbeef;
      valid_DM = 1'b0;
      data_rd  = '0;
   end

   always @(negedge clk) begin
      if (!cs && !wr) begin
         for (int b = 0; b < 4; b++)
            if (mask[b]) mem[addr[7:0]][8*b +: 8] = data_wr[8*b +: 8];
      end
      if (!cs && wr) begin
         if (lat_cnt >= cur_lat) begin
            valid_DM = 1'b1;
            data_rd  = mem[addr[7:0]];
         end else begin
            valid_DM = 1'b0;
            data_rd  = 32'h0;
         end
         lat_cnt++;
      end else begin
         // spur drives a stray valid while no load is pending
         valid_DM = spur;
         data_rd  = 32'h55555555;
         lat_cnt  = 0;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          lat;
      logic        spur;
      logic        mis;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [3:0]  exp_mask;
      logic [31:0] exp_dw;
      int          exp_lcyc;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int lat, input logic sp,
                               input logic mis, input logic [31:0] rd, input logic er,
                               input logic [3:0] m, input logic [31:0] dw, input int lc);
      vec_t v;
      v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.lat = lat; v.spur = sp; v.mis = mis;
      v.exp_rd = rd; v.exp_err = er; v.exp_mask = m; v.exp_dw = dw; v.exp_lcyc = lc;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int          wrc, lcyc, stall_bad;
      logic        done;
      logic [3:0]  m;
      logic [31:0] dw;
      logic [19:0] wa;
      wrc = 0; lcyc = 0; stall_bad = 0; done = 1'b0;
      m = '0; dw = '0; wa = '0;
      cur_lat    = v.lat;
      spur       = v.spur;
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.a;
      req_wdata  = v.wd;
      @(negedge clk);
      chk($sformatf("v%0d.ready", idx), req_ready, 1);
      if (v.mis) begin
         chk($sformatf("v%0d.mis_valid", idx), rsp_valid, 1);
         chk($sformatf("v%0d.mis_err", idx), rsp_err, 1);
         chk($sformatf("v%0d.mis_cs", idx), cs, 1);
         chk($sformatf("v%0d.mis_stall", idx), stall, 0);
         @(posedge clk); #1;
         req_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d.mis_idle", idx), req_ready, 1);
         chk($sformatf("v%0d.mis_nopulse", idx), rsp_valid, 0);
         chk($sformatf("v%0d.mis_cs2", idx), cs, 1);
         @(posedge clk); #1;
         spur = 1'b0;
         return;
      end
      chk($sformatf("v%0d.acc_stall", idx), stall, 1);
      chk($sformatf("v%0d.acc_nopulse", idx), rsp_valid, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            done = 1'b1;
            chk($sformatf("v%0d.rsp_stall", idx), stall, 0);
            chk($sformatf("v%0d.rsp_lwstall", idx), lwstallM_DM, 0);
            chk($sformatf("v%0d.rsp_err", idx), rsp_err, v.exp_err);
            if (!v.we) chk($sformatf("v%0d.rdata", idx), rsp_rdata, v.exp_rd);
         end else begin
            if (!stall) stall_bad++;
            if (!cs && !wr) begin
               wrc++; m = mask; dw = data_wr; wa = addr;
            end
            if (lwstallM_DM) lcyc++;
         end
      end
      chk($sformatf("v%0d.rsp_seen", idx), done, 1);
      chk($sformatf("v%0d.stall_hold", idx), stall_bad, 0);
      chk($sformatf("v%0d.wr_cycles", idx), wrc, v.we ? 1 : 0);
      if (v.we) begin
         chk($sformatf("v%0d.mask", idx), m, v.exp_mask);
         chk($sformatf("v%0d.data_wr", idx), dw, v.exp_dw);
         chk($sformatf("v%0d.addr", idx), wa, v.a[21:2]);
      end else begin
         chk($sformatf("v%0d.load_cycles", idx), lcyc, v.exp_lcyc);
      end
      @(posedge clk); #1;
      spur = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int   pulses;
      // we  f3      addr          wdata         lat sp mis exp_rd        err mask     data_wr       lcyc
      vecs.push_back(mk(0, 3'b000, 32'h00000003, 32'h0,        0, 0, 0, 32'hffffffde, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(0, 3'b100, 32'h00000003, 32'h0,        2, 0, 0, 32'h000000de, 0, 4'h0, 32'h0,        3));
      vecs.push_back(mk(0, 3'b001, 32'h00000002, 32'h0,        1, 0, 0, 32'hffffdead, 0, 4'h0, 32'h0,        2));
      vecs.push_back(mk(0, 3'b101, 32'h00000000, 32'h0,        0, 0, 0, 32'h0000beef, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(0, 3'b100, 32'h00000001, 32'h0,        3, 1, 0, 32'h000000be, 0, 4'h0, 32'h0,        4));
      vecs.push_back(mk(1, 3'b000, 32'h00000005, 32'h12345678, 0, 1, 0, 32'h0,        0, 4'h2, 32'h78787878, 0));
      vecs.push_back(mk(0, 3'b010, 32'h00000004, 32'h0,        0, 0, 0, 32'hdead78ef, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(1, 3'b001, 32'h0000000a, 32'h0000cafe, 0, 0, 0, 32'h0,        0, 4'hc, 32'hcafecafe, 0));
      vecs.push_back(mk(0, 3'b010, 32'h00000008, 32'h0,        1, 0, 0, 32'hcafebeef, 0, 4'h0, 32'h0,        2));
      vecs.push_back(mk(1, 3'b010, 32'h0000000c, 32'ha5a50f0f, 0, 0, 0, 32'h0,        0, 4'hf, 32'ha5a50f0f, 0));
      vecs.push_back(mk(0, 3'b001, 32'h0000000e, 32'h0,        0, 0, 0, 32'hffffa5a5, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(0, 3'b101, 32'h0000000c, 32'h0,        0, 0, 0, 32'h00000f0f, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(0, 3'b011, 32'h00000008, 32'h0,        0, 0, 0, 32'hcafebeef, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(1, 3'b111, 32'h00000010, 32'h11223344, 0, 0, 0, 32'h0,        0, 4'hf, 32'h11223344, 0));
      vecs.push_back(mk(0, 3'b010, 32'h00000010, 32'h0,        0, 0, 0, 32'h11223344, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(0, 3'b010, 32'hffc00004, 32'h0,        0, 0, 0, 32'hdead78ef, 0, 4'h0, 32'h0,        1));
      vecs.push_back(mk(0, 3'b010, 32'h00000006, 32'h0,        0, 0, 1, 32'h0,        1, 4'h0, 32'h0,        0));
      vecs.push_back(mk(0, 3'b001, 32'h00000001, 32'h0,        0, 0, 1, 32'h0,        1, 4'h0, 32'h0,        0));
      vecs.push_back(mk(1, 3'b010, 32'h00000002, 32'hffffffff, 0, 0, 1, 32'h0,        1, 4'h0, 32'h0,        0));
      vecs.push_back(mk(1, 3'b001, 32'h00000003, 32'hffffffff, 0, 0, 1, 32'h0,        1, 4'h0, 32'h0,        0));
      vecs.push_back(mk(0, 3'b010, 32'h00000000, 32'h0,        1, 0, 0, 32'hdeadbeef, 0, 4'h0, 32'h0,        2));
      vecs.push_back(mk(0, 3'b010, 32'h00000000, 32'h0,       99, 0, 0, 32'h00000000, 1, 4'h0, 32'h0,       15));
      vecs.push_back(mk(0, 3'b010, 32'h00000000, 32'h0,       14, 0, 0, 32'hdeadbeef, 0, 4'h0, 32'h0,       15));
      vecs.push_back(mk(0, 3'b000, 32'h00000001, 32'h0,        0, 0, 0, 32'hffffffbe, 0, 4'h0, 32'h0,        1));

      // reset state
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.req_ready", req_ready, 1);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rsp_err", rsp_err, 0);
      chk("rst.rsp_rdata", rsp_rdata, 0);
      chk("rst.stall", stall, 0);
      chk("rst.cs", cs, 1);
      chk("rst.wr", wr, 1);
      chk("rst.mask", mask, 0);
      chk("rst.data_wr", data_wr, 0);
      chk("rst.addr", addr, 0);
      chk("rst.lwstall", lwstallM_DM, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // reset on the second LOAD cycle: abandoned without a response
      cur_lat = 99;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rl.in_load", lwstallM_DM, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rl.cs", cs, 1);
      chk("rl.req_ready", req_ready, 1);
      chk("rl.rsp_valid", rsp_valid, 0);
      chk("rl.lwstall", lwstallM_DM, 0);
      chk("rl.stall", stall, 0);
      chk("rl.rsp_rdata", rsp_rdata, 0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      chk("rl.no_pulse", pulses, 0);
      @(posedge clk); #1;

      // reset during the STORE cycle
      cur_lat = 0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h00000020; req_wdata = 32'h0badf00d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rs.in_store", {cs, wr}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rs.cs", cs, 1);
      chk("rs.rsp_valid", rsp_valid, 0);
      chk("rs.req_ready", req_ready, 1);
      chk("rs.data_wr", data_wr, 0);
      @(posedge clk); #1;

      // normal operation after the aborted accesses
      run_vec(mk(0, 3'b010, 32'h00000004, 32'h0, 2, 0, 0, 32'hdead78ef, 0, 4'h0, 32'h0, 3), 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
